// File: rtl/gw5ast_pkg.sv
// rtl/gw5ast_pkg.sv - shared sizing constants and work-item type for the dispatcher
package gw5ast_pkg;

    localparam int N_CORES    = 8;
    localparam int DATA_WIDTH = 24;
    localparam int CNT_WIDTH  = 16;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/gw5ast_sync_fifo.sv
// rtl/gw5ast_sync_fifo.sv - power-of-two synchronous FIFO with flush, full/empty flags
module gw5ast_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: the occupancy count decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gw5ast_dispatch.sv
// rtl/gw5ast_dispatch.sv - round-robin work dispatcher, FIFO to per-core slots (option: GW5AST_DISPATCH_BCAST_EN)
module gw5ast_dispatch #(
    parameter int N_CORES    = gw5ast_pkg::N_CORES,
    parameter int DATA_WIDTH = gw5ast_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
`ifdef GW5AST_DISPATCH_BCAST_EN
    input  logic                          in_bcast,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [N_CORES*DATA_WIDTH-1:0] core_data,
    output logic [N_CORES-1:0]            core_valid,
    input  logic [N_CORES-1:0]            core_ready,
    input  logic                          flush,
    output logic                          idle,
    output logic [15:0]                   dispatched_cnt
);

    localparam int PW    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CNT_W = gw5ast_pkg::CNT_WIDTH;
`ifdef GW5AST_DISPATCH_BCAST_EN
    localparam int FW = DATA_WIDTH + 1;
`else
    localparam int FW = DATA_WIDTH;
`endif

    logic [FW-1:0]         fifo_wr;
    logic [FW-1:0]         fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_bcast;
    logic [N_CORES-1:0]    hs;
    logic [N_CORES-1:0]    load;
    logic [CNT_W-1:0]      hs_cnt;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         grant_ix;
    logic [PW-1:0]         cand;
    logic                  found;

    // in_ready depends only on registered occupancy, flush and reset.
    assign in_ready  = rst_n && !fifo_full && !flush;
    assign push      = in_valid && in_ready;
    assign head_data = fifo_rd[DATA_WIDTH-1:0];
    assign hs        = core_valid & core_ready;
    assign idle      = fifo_empty && (core_valid == '0);

`ifdef GW5AST_DISPATCH_BCAST_EN
    assign fifo_wr    = {in_bcast, in_data};
    assign head_bcast = fifo_rd[DATA_WIDTH];
`else
    assign fifo_wr    = in_data;
    assign head_bcast = 1'b0;
`endif

    gw5ast_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (fifo_wr),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Round-robin search for the first empty slot after the last grant.
    always_comb begin
        grant_ix = rr_ptr;
        cand     = rr_ptr;
        found    = 1'b0;
        for (int k = 1; k <= N_CORES; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_CORES);
            if (!found && !core_valid[cand]) begin
                found    = 1'b1;
                grant_ix = cand;
            end
        end
    end

    // Move the head item: broadcast needs every slot empty, normal items need one free slot.
    always_comb begin
        load = '0;
        pop  = 1'b0;
        if (!fifo_empty && !flush) begin
            if (head_bcast) begin
                if (core_valid == '0) begin
                    load = '1;
                    pop  = 1'b1;
                end
            end else if (found) begin
                load[grant_ix] = 1'b1;
                pop            = 1'b1;
            end
        end
    end

    // Number of core handshakes completing this cycle.
    always_comb begin
        hs_cnt = '0;
        for (int i = 0; i < N_CORES; i++) begin
            hs_cnt = hs_cnt + CNT_W'(hs[i]);
        end
    end

    // Per-core output slots: hold until handshake, cleared wholesale by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_valid <= '0;
            core_data  <= '0;
        end else if (flush) begin
            core_valid <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (load[i]) begin
                    core_valid[i]                             <= 1'b1;
                    core_data[i*DATA_WIDTH +: DATA_WIDTH]     <= head_data;
                end else if (hs[i]) begin
                    core_valid[i]                             <= 1'b0;
                end
            end
        end
    end

    // Handshake counter and round-robin pointer survive flush; broadcast leaves the pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatched_cnt <= '0;
            rr_ptr         <= PW'(N_CORES - 1);
        end else begin
            dispatched_cnt <= dispatched_cnt + hs_cnt;
            if (pop && !head_bcast) begin
                rr_ptr <= grant_ix;
            end
        end
    end

endmodule

// File: tb/tb_gw5ast_dispatch.sv
// tb/tb_gw5ast_dispatch.sv - self-checking bench for gw5ast_dispatch (option: GW5AST_DISPATCH_BCAST_EN)
module tb_gw5ast_dispatch;
    import gw5ast_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic                          clk = 1'b0;
    logic                          rst_n;
    word_t                         in_data;
    logic                          in_bcast_v;
    logic                          in_valid;
    logic                          in_ready;
    logic [N_CORES*DATA_WIDTH-1:0] core_data;
    logic [N_CORES-1:0]            core_valid;
    logic [N_CORES-1:0]            core_ready;
    logic                          flush;
    logic                          idle;
    logic [15:0]                   dispatched_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct { word_t data; bit bc; } item_t;
    item_t              mq[$];
    logic [N_CORES-1:0] m_valid;
    word_t              m_data [N_CORES];
    int                 m_last;
    logic [15:0]        m_cnt;

    always #5 clk = ~clk;

    gw5ast_dispatch #(
        .N_CORES    (N_CORES),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
`ifdef GW5AST_DISPATCH_BCAST_EN
        .in_bcast       (in_bcast_v),
`endif
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .core_data      (core_data),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .flush          (flush),
        .idle           (idle),
        .dispatched_cnt (dispatched_cnt)
    );

    function automatic word_t slot(int i);
        return core_data[i*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = '0;
        for (int i = 0; i < N_CORES; i++) m_data[i] = '0;
        m_last = N_CORES - 1;
        m_cnt  = '0;
    endtask

    // Behavioural view of one clock edge: count handshakes, move the head item, then accept.
    task automatic model_step();
        logic [N_CORES-1:0] hsv;
        logic [N_CORES-1:0] nv;
        bit acc;
        bit done;
        int j;
        item_t it;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hsv = m_valid & core_ready;
        for (int i = 0; i < N_CORES; i++) if (hsv[i]) m_cnt = m_cnt + 16'd1;
        acc = in_valid && (mq.size() < FIFO_DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            m_valid = '0;
        end else begin
            nv = m_valid & ~hsv;
            if (mq.size() > 0) begin
                if (mq[0].bc) begin
                    if (m_valid == '0) begin
                        for (int i = 0; i < N_CORES; i++) begin
                            nv[i] = 1'b1;
                            m_data[i] = mq[0].data;
                        end
                        void'(mq.pop_front());
                    end
                end else begin
                    done = 1'b0;
                    for (int k = 1; k <= N_CORES; k++) begin
                        j = (m_last + k) % N_CORES;
                        if (!done && !m_valid[j]) begin
                            done = 1'b1;
                            nv[j] = 1'b1;
                            m_data[j] = mq[0].data;
                            m_last = j;
                        end
                    end
                    if (done) void'(mq.pop_front());
                end
            end
            m_valid = nv;
            if (acc) begin
                it.data = in_data;
                it.bc   = in_bcast_v;
                mq.push_back(it);
            end
        end
    endtask

    task automatic compare();
        check("in_ready", in_ready, (mq.size() < FIFO_DEPTH) && !flush && rst_n);
        check("core_valid", core_valid, m_valid);
        for (int i = 0; i < N_CORES; i++)
            if (m_valid[i]) check($sformatf("core_data[%0d]", i), slot(i), m_data[i]);
        check("idle", idle, (mq.size() == 0) && (m_valid == '0));
        check("dispatched_cnt", dispatched_cnt, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic push_item(word_t d, bit bc);
        int n;
        bit will;
        n = 0;
        in_valid   = 1'b1;
        in_data    = d;
        in_bcast_v = bc;
        do begin
            will = (mq.size() < FIFO_DEPTH) && !flush && rst_n;
            tick();
            n++;
        end while (!will && n < 200);
        in_valid   = 1'b0;
        in_bcast_v = 1'b0;
        check("push_accept", will, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!((mq.size() == 0) && (m_valid == '0)) && n < 200) begin
            tick();
            n++;
        end
        check("wait_idle", (mq.size() == 0) && (m_valid == '0), 1);
    endtask

    initial begin
        word_t seen[$];
        logic [15:0] saved_cnt;
        int n;
        bit will;

        rst_n = 1'b0; in_data = '0; in_bcast_v = 1'b0; in_valid = 1'b0;
        core_ready = '0; flush = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_idle", idle, 1);
        check("rst_core_valid", core_valid, 0);
        check("rst_cnt", dispatched_cnt, 0);
        for (int i = 0; i < N_CORES; i++) check("rst_core_data", slot(i), 0);
        rst_n = 1'b1;
        tick();

        // In-order spread over cores 0..7, each visible one edge after acceptance.
        core_ready = '1;
        for (int k = 1; k <= 8; k++) begin
            push_item(word_t'(k), 1'b0);
            if (k == 1) check("first_latency", core_valid, 0);
            else begin
                check("seq_valid", core_valid, 8'(1 << (k - 2)));
                check("seq_data", slot(k - 2), k - 1);
            end
        end
        tick();
        check("seq_valid_last", core_valid, 8'h80);
        check("seq_data_last", slot(7), 8);
        tick();
        check("seq_cnt", dispatched_cnt, 8);

        // Backpressure: 8 slots plus 4 FIFO entries, then only core 3 drains.
        core_ready = '0;
        for (int k = 1; k <= 12; k++) push_item(word_t'(k), 1'b0);
        in_valid = 1'b1; in_data = 24'd13;
        tick(); tick();
        check("bp_in_ready", in_ready, 0);
        check("bp_core_valid", core_valid, 8'hFF);
        core_ready = 8'h08;
        n = 0;
        while (seen.size() < 6 && n < 60) begin
            will = in_valid && (mq.size() < FIFO_DEPTH);
            if (core_valid[3]) seen.push_back(slot(3));
            tick();
            if (will) in_valid = 1'b0;
            n++;
        end
        check("bp_seen_count", seen.size(), 6);
        for (int k = 0; k < 6 && k < seen.size(); k++)
            check("bp_core3_item", seen[k], (k == 0) ? 4 : 8 + k);

        // Flush with FIFO and slots full keeps the counter and the pointer.
        core_ready = '0;
        for (int k = 0; k < 5; k++) push_item(word_t'(24'h100 + k), 1'b0);
        check("fl_in_ready", in_ready, 0);
        check("fl_core_valid_full", core_valid, 8'hFF);
        saved_cnt = dispatched_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_core_valid", core_valid, 0);
        check("fl_idle", idle, 1);
        check("fl_cnt", dispatched_cnt, saved_cnt);
        push_item(24'h200, 1'b0);
        tick();
        check("fl_next_core", core_valid, 8'h10);
        check("fl_next_data", slot(4), 24'h200);
        core_ready = '1;
        wait_idle();

        // Asynchronous reset in the middle of a stream.
        core_ready = '0;
        for (int k = 0; k < 10; k++) push_item(word_t'(24'h300 + k), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_core_valid", core_valid, 0);
        check("ar_in_ready", in_ready, 0);
        check("ar_idle", idle, 1);
        check("ar_cnt", dispatched_cnt, 0);
        for (int i = 0; i < N_CORES; i++) check("ar_core_data", slot(i), 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        core_ready = '1;
        for (int k = 0; k < 10; k++) tick();
        check("ar_no_delivery", dispatched_cnt, 0);

        // Counter wrap: 0xFFFE handshakes, then three in the same cycle.
        for (int k = 0; k < 65534; k++) push_item(word_t'($urandom), 1'b0);
        wait_idle();
        check("wrap_preload", dispatched_cnt, 16'hFFFE);
        core_ready = '0;
        for (int k = 0; k < 3; k++) push_item(word_t'(24'h400 + k), 1'b0);
        tick(); tick();
        check("wrap_slots", core_valid, 8'hC1);
        core_ready = '1;
        tick();
        check("wrap_cnt", dispatched_cnt, 16'h0001);

`ifdef GW5AST_DISPATCH_BCAST_EN
        // Broadcast waits behind two normal items, then fills every core at once.
        core_ready = '0;
        push_item(24'h000001, 1'b0);
        push_item(24'h000002, 1'b0);
        push_item(24'hABCDEF, 1'b1);
        tick(); tick();
        check("bc_wait", core_valid, 8'h06);
        core_ready = '1;
        tick();
        check("bc_drain", core_valid, 0);
        tick();
        check("bc_all", core_valid, 8'hFF);
        for (int i = 0; i < N_CORES; i++) check("bc_data", slot(i), 24'hABCDEF);
        wait_idle();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = word_t'($urandom);
            core_ready = ($urandom_range(0, 3) == 0) ? '0 : N_CORES'($urandom);
            flush      = ($urandom_range(0, 40) == 0);
`ifdef GW5AST_DISPATCH_BCAST_EN
            in_bcast_v = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end
        in_valid = 1'b0; in_bcast_v = 1'b0; flush = 1'b0; core_ready = '1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gw5ast_dispatch.md
GW5AST_DISPATCH -- requirements
Module: gw5ast_dispatch

Interface
REQ-001 SHALL have parameter N_CORES, default 8: number of downstream cores.
REQ-002 SHALL have parameter DATA_WIDTH, default 24: work-item width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: input FIFO entries, power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports in_data (input, DATA_WIDTH), in_valid (input, 1) and in_ready (output, 1): upstream work-item valid/ready channel.
REQ-007 SHALL have ports core_data (output, N_CORES x DATA_WIDTH), core_valid (output, N_CORES) and core_ready (input, N_CORES): per-core valid/ready channel into the core array.
REQ-008 SHALL have port flush, input, 1: synchronous discard of all buffered work.
REQ-009 SHALL have port idle, output, 1: high when the FIFO is empty and no core slot is valid.
REQ-010 SHALL have port dispatched_cnt, output, 16: count of completed core handshakes.

Function
REQ-011 SHALL accept an item on any cycle with in_valid and in_ready both high; in_ready = FIFO not full and flush low, with no combinational path from in_valid or core_ready.
REQ-012 SHALL hold one output slot per core; core_valid[i] and core_data[i] SHALL stay stable until core_ready[i] is sampled high.
REQ-013 SHALL pop at most one FIFO item per cycle into exactly one empty slot; a slot freed by a handshake becomes eligible on the following cycle.
REQ-014 SHALL choose the target slot round-robin: search starts at (last granted + 1) mod N_CORES; the pointer updates only on a grant.
REQ-015 SHALL give minimum latency 2: item accepted at edge t is visible on core_valid at t+1 edge, when the FIFO is empty and a slot is free.
REQ-016 SHALL support simultaneous push and pop when full; in_ready stays low while full regardless of pop in that cycle.
REQ-017 SHALL wrap FIFO pointers modulo FIFO_DEPTH; items leave in FIFO order.
REQ-018 SHALL increment dispatched_cnt by popcount(core_valid & core_ready) each cycle, wrapping modulo 2^16.
REQ-019 SHALL on flush high clear the FIFO and all core_valid bits at the next edge; flush has priority over push and pop in that cycle; dispatched_cnt and the round-robin pointer are kept.
REQ-020 SHALL on a handshake coinciding with flush count the handshake.

Reset
REQ-021 SHALL on rst_n low immediately clear the FIFO, core_valid, core_data (0), dispatched_cnt (0) and the round-robin pointer (N_CORES-1, so core 0 is first), with in_ready low and idle high.
REQ-022 SHALL on reset assertion mid-transfer lose all buffered items; the first cycle after deassertion behaves as post-reset.

Configuration
REQ-023 SHALL, with GW5AST_DISPATCH_BCAST_EN defined, add input in_bcast (1) sampled with in_data and stored per entry; a broadcast head item waits until all slots are empty, then loads every slot in one cycle and leaves the pointer unchanged.
REQ-024 SHALL, without GW5AST_DISPATCH_BCAST_EN, omit in_bcast and the per-entry flag; all items are round-robin.

Structure
REQ-025 SHALL take N_CORES, DATA_WIDTH and typedef word_t from shared package gw5ast_pkg.
REQ-026 SHALL implement the input buffer as sub-module gw5ast_sync_fifo (parameters WIDTH, DEPTH; full/empty outputs).

Verification
REQ-027 SHALL cover: reset, push 0x000001..0x000008 with all core_ready high -> core 0..7 each receive one item in order; first core_valid 2 cycles after first accept; dispatched_cnt=8.
REQ-028 SHALL cover: core_ready all low, push 13 items -> 8 slots filled, 4 in FIFO, in_ready low, 13th item held by upstream; then raise core_ready[3] only -> core 3 takes 0x000009..0x00000C in successive frees.
REQ-029 SHALL cover: full FIFO and slots, assert flush for one cycle -> next cycle core_valid=0, idle=1, dispatched_cnt unchanged, next push goes to the core after the last grant.
REQ-030 SHALL cover: rst_n pulsed low mid-stream with items buffered -> outputs reset asynchronously, no item delivered after release.
REQ-031 SHALL cover: dispatched_cnt preloaded to 0xFFFE by 0xFFFE handshakes, then 3 simultaneous handshakes -> 0x0001.
REQ-032 SHALL cover, with GW5AST_DISPATCH_BCAST_EN: broadcast item 0xABCDEF behind two normal items -> all 8 cores show 0xABCDEF together only after both earlier slots drain.
